iob_eth_axi_mem_slave: RTL
==========================

Name: iob_eth_axi_mem_slave

Overview:
AXI4 responder that serves the Ethernet DMA master's INCR bursts from an internal word-addressed RAM. It acts as the external-memory end for buffer-pointer frame reads (TX) and frame writes (RX) in eth simulation and standalone testbenches. Transfers are 4 bytes only and always INCR, so size, burst, lock, cache, prot and qos are not ported. Independent read and write channels, each with one outstanding transaction.

Parameters:
AXI_ADDR_W, 24, byte address width
AXI_DATA_W, 32, data width; only 32 supported
AXI_LEN_W, 8, burst length field width
AXI_ID_W, 1, transaction ID width
MEM_ADDR_W, 12, RAM depth log2 in 32-bit words

Ports:
clk_i  in  1  clock
arst_n_i  in  1  async reset, active-low
axi_awid_i  in  AXI_ID_W  write ID
axi_awaddr_i  in  AXI_ADDR_W  write start byte address
axi_awlen_i  in  AXI_LEN_W  write beats minus 1
axi_awvalid_i  in  1  AW valid
axi_awready_o  out  1  AW ready
axi_wdata_i  in  32  write data
axi_wstrb_i  in  4  byte enables
axi_wlast_i  in  1  last write beat
axi_wvalid_i  in  1  W valid
axi_wready_o  out  1  W ready
axi_bid_o  out  AXI_ID_W  echoed AW ID
axi_bresp_o  out  2  write response
axi_bvalid_o  out  1  B valid
axi_bready_i  in  1  B ready
axi_arid_i  in  AXI_ID_W  read ID
axi_araddr_i  in  AXI_ADDR_W  read start byte address
axi_arlen_i  in  AXI_LEN_W  read beats minus 1
axi_arvalid_i  in  1  AR valid
axi_arready_o  out  1  AR ready
axi_rid_o  out  AXI_ID_W  echoed AR ID
axi_rdata_o  out  32  read data
axi_rresp_o  out  2  read response, always 2'b00
axi_rlast_o  out  1  last read beat
axi_rvalid_o  out  1  R valid
axi_rready_i  in  1  R ready

Behaviour:
- Reset (arst_n_i low, async): all outputs 0, except awready=1 and arready=1. Both FSMs go to IDLE. RAM contents are not reset. Reset mid-burst drops the transaction with no B or R response.
- Word index = byte_addr[MEM_ADDR_W+1:2]. Address bits [1:0] and bits above MEM_ADDR_W+1 are ignored. The word index increments per beat and wraps modulo 2^MEM_ADDR_W.
- Write FSM W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id, word index, len and beat count 0; awready<=0; wready<=1; go to W_DATA.
  - W_DATA: each W handshake writes the bytes selected by wstrb to RAM[idx] on that clock edge, then idx++ and count++. The burst ends on the beat where count==len, regardless of wlast.
  - wlast mismatch (wlast=1 before the final beat, or 0 on the final beat) sets an error flag. All beats are still written.
  - At burst end: wready<=0; bvalid<=1; bresp = 2'b10 if error flag else 2'b00; bid = latched id.
  - W_RESP: hold B until bready; then bvalid<=0, awready<=1, clear error flag, go to W_IDLE.
- Read FSM R_IDLE -> R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch id, idx and len; arready<=0; rdata<=RAM[idx]; rvalid<=1; rlast<=(len==0).
  - First beat is valid on the cycle after the AR handshake (1-cycle latency).
  - R_DATA: rdata, rlast and rid are stable while rvalid=1 and rready=0.
  - On an R handshake that is not last: rdata<=RAM[idx+1]; rlast<=(count+1==len). Sustains 1 beat/cycle with rready held high.
  - On the last-beat handshake: rvalid<=0, rlast<=0, arready<=1, go to R_IDLE.
- Read/write collision on the same word in the same cycle: the read captures the pre-write value.
- AW and AR may handshake in the same cycle. The channels are fully independent.
- Arithmetic: beat counters are AXI_LEN_W bits. len=255 produces 256 beats.

Test Plan:
- Write idx 0x10, awlen=3, data A0..A3, wstrb=F, wlast on 4th beat -> bresp=00, bid echoed; read back same address with arlen=3 -> A0..A3, rlast only on beat 4, rvalid 1 cycle after AR handshake.
- wstrb=4'b0101 over 0xFFFFFFFF preload, wdata 0x11223344 -> read returns 0xFF22FF44.
- awlen=1 with wlast on beat 0 -> both beats written, bresp=2'b10; next clean burst -> bresp=00.
- Burst starting at word 2^MEM_ADDR_W-2, len=3 -> beats land in words 4094, 4095, 0, 1 (MEM_ADDR_W=12).
- rready toggled randomly during a 16-beat read -> no beat lost or duplicated, rdata stable while stalled; simultaneous AW/AR handshakes on the same word -> read sees old data.
- arst_n_i pulsed low mid-write burst -> awready=arready=1, bvalid=rvalid=wready=0; a fresh burst then completes normally.

Source files
------------

// File: rtl/iob_eth_axi_mem_slave_if.sv
// AXI4 subset (INCR, 4-byte beats) between the Ethernet DMA master and the memory responder.
interface iob_eth_axi_mem_slave_if #(
  parameter int unsigned AXI_ADDR_W = 24,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  parameter int unsigned AXI_ID_W   = 1
);
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [AXI_LEN_W-1:0]    awlen;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [AXI_LEN_W-1:0]    arlen;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/iob_eth_axi_mem_slave.sv
// AXI4 memory responder: serves INCR bursts of 32-bit beats from a word-addressed RAM,
// with independent read and write channels, one outstanding transaction each.
module iob_eth_axi_mem_slave #(
  parameter int unsigned AXI_ADDR_W = 24,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned MEM_ADDR_W = 12
) (
  input logic                     clk_i,
  input logic                     arst_n_i,
  iob_eth_axi_mem_slave_if.slave  axi
);

  localparam int unsigned StrbW = AXI_DATA_W / 8;
  localparam int unsigned Depth = 2 ** MEM_ADDR_W;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [AXI_DATA_W-1:0] mem_q [Depth];

  w_state_e              w_state_q;
  logic                  awready_q, wready_q, bvalid_q, w_err_q;
  logic [1:0]            bresp_q;
  logic [AXI_ID_W-1:0]   w_id_q;
  logic [MEM_ADDR_W-1:0] w_idx_q;
  logic [AXI_LEN_W-1:0]  w_len_q, w_cnt_q;

  r_state_e              r_state_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [AXI_ID_W-1:0]   r_id_q;
  logic [MEM_ADDR_W-1:0] r_idx_q;
  logic [AXI_LEN_W-1:0]  r_len_q, r_cnt_q;

  logic [MEM_ADDR_W-1:0] aw_idx, ar_idx;
  logic                  w_hs, w_final, unused_addr;

  assign aw_idx  = axi.awaddr[MEM_ADDR_W+1:2];
  assign ar_idx  = axi.araddr[MEM_ADDR_W+1:2];
  assign w_hs    = (w_state_q == WData) && axi.wvalid && wready_q;
  assign w_final = (w_cnt_q == w_len_q);
  assign unused_addr = ^{axi.awaddr[AXI_ADDR_W-1:MEM_ADDR_W+2], axi.awaddr[1:0],
                         axi.araddr[AXI_ADDR_W-1:MEM_ADDR_W+2], axi.araddr[1:0]};

  // RAM is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      for (int b = 0; b < StrbW; b++) begin
        if (axi.wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      w_state_q <= WIdle;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      w_err_q   <= 1'b0;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (axi.awvalid) begin
            w_id_q    <= axi.awid;
            w_idx_q   <= aw_idx;
            w_len_q   <= axi.awlen;
            w_cnt_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= WData;
          end
        end
        WData: begin
          if (w_hs) begin
            w_idx_q <= w_idx_q + MEM_ADDR_W'(1);
            w_cnt_q <= w_cnt_q + AXI_LEN_W'(1);
            // Burst length comes from awlen; wlast only flags a protocol error.
            if (w_final) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || !axi.wlast) ? 2'b10 : 2'b00;
              w_state_q <= WResp;
            end else if (axi.wlast) begin
              w_err_q <= 1'b1;
            end
          end
        end
        WResp: begin
          if (axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_err_q   <= 1'b0;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // r_idx_q always points at the word to fetch for the next beat.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state_q <= RIdle;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (axi.arvalid) begin
            r_id_q    <= axi.arid;
            r_idx_q   <= ar_idx + MEM_ADDR_W'(1);
            r_len_q   <= axi.arlen;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rdata_q   <= mem_q[ar_idx];
            rvalid_q  <= 1'b1;
            rlast_q   <= (axi.arlen == '0);
            r_state_q <= RData;
          end
        end
        RData: begin
          if (axi.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= RIdle;
            end else begin
              rdata_q <= mem_q[r_idx_q];
              r_idx_q <= r_idx_q + MEM_ADDR_W'(1);
              r_cnt_q <= r_cnt_q + AXI_LEN_W'(1);
              rlast_q <= ((r_cnt_q + AXI_LEN_W'(1)) == r_len_q);
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.bid     = w_id_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rdata   = rdata_q;
  assign axi.rid     = r_id_q;
  assign axi.rresp   = 2'b00;

endmodule
